// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, optional write-to-read bypass
// and a per-register busy scoreboard (reserve at issue, clear at writeback).
module regfile_mp #(
   parameter int DEPTH    = 32,
   parameter int DW       = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_RD-1:0]    rd_en,
   input  logic [NUM_RD*AW-1:0] rs_s,
   output logic [NUM_RD*DW-1:0] rs_v,
   output logic [NUM_RD-1:0]    rs_busy,
   input  logic [NUM_WR-1:0]    we,
   input  logic [NUM_WR*AW-1:0] rd_s,
   input  logic [NUM_WR*DW-1:0] rd_v,
   input  logic                 rsv_en,
   input  logic [AW-1:0]        rsv_s
);

   logic [DW-1:0]     mem [DEPTH];
   logic [DEPTH-1:0]  busy;

   logic [NUM_WR-1:0] wr_ok;
   logic [AW-1:0]     wa [NUM_WR];
   logic [DW-1:0]     wd [NUM_WR];
   logic              rsv_ok;

   // Writes and reserves aimed at a hardwired zero register are dropped here,
   // so neither the array, the scoreboard nor the bypass path ever sees them.
   for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
      assign wa[j]    = rd_s[j*AW +: AW];
      assign wd[j]    = rd_v[j*DW +: DW];
      assign wr_ok[j] = we[j] && !((ZERO_REG != 0) && (wa[j] == '0));
   end

   assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_s == '0));

   // Ascending port order makes the highest write port win; the reserve comes
   // last so a same-cycle set beats the writeback clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
         busy <= '0;
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_ok[j]) begin
               mem[wa[j]]  <= wd[j];
               busy[wa[j]] <= 1'b0;
            end
         end
         if (rsv_ok) busy[rsv_s] <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0] ra;
      logic [DW-1:0] v_nxt, v_q;
      logic          b_nxt, b_q;

      assign ra = rs_s[i*AW +: AW];

      // With bypass the port samples the next-state value of the entry.
      always_comb begin
         v_nxt = mem[ra];
         b_nxt = busy[ra];
         if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (wr_ok[j] && (wa[j] == ra)) begin
                  v_nxt = wd[j];
                  b_nxt = 1'b0;
               end
            end
            if (rsv_ok && (rsv_s == ra)) b_nxt = 1'b1;
         end
         if ((ZERO_REG != 0) && (ra == '0)) begin
            v_nxt = '0;
            b_nxt = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= '0;
            b_q <= 1'b0;
         end else if (rd_en[i]) begin
            v_q <= v_nxt;
            b_q <= b_nxt;
         end
      end

      assign rs_v[i*DW +: DW] = v_q;
      assign rs_busy[i]       = b_q;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one bypassing and one non-bypassing instance share
// stimulus; checked against directed vectors and an array-based reference model.
module tb_regfile_mp;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    rd_en = '0;
   logic [9:0]    rs_s = '0;
   logic [1:0]    we = '0;
   logic [9:0]    rd_s = '0;
   logic [63:0]   rd_v = '0;
   logic          rsv_en = 1'b0;
   logic [4:0]    rsv_s = '0;
   logic [63:0]   v_byp, v_nb;
   logic [1:0]    b_byp, b_nb;

   regfile_mp #(.DEPTH(32), .DW(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)) u_byp (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rs_s(rs_s), .rs_v(v_byp), .rs_busy(b_byp),
      .we(we), .rd_s(rd_s), .rd_v(rd_v), .rsv_en(rsv_en), .rsv_s(rsv_s));

   regfile_mp #(.DEPTH(32), .DW(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_REG(1)) u_nb (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rs_s(rs_s), .rs_v(v_nb), .rs_busy(b_nb),
      .we(we), .rd_s(rd_s), .rd_v(rd_v), .rsv_en(rsv_en), .rsv_s(rsv_s));

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Reference model: architectural registers plus expected registered outputs.
   logic [31:0] m [32];
   logic        bz [32];
   logic [31:0] ev_b [2], ev_n [2];
   logic        eb_b [2], eb_n [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 32; k++) begin
         m[k] = '0;
         bz[k] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         ev_b[i] = '0; ev_n[i] = '0; eb_b[i] = 1'b0; eb_n[i] = 1'b0;
      end
   endtask

   // Apply one clock of architectural effect: the bypassing file reads the
   // post-update state, the other the pre-update state; register 0 is always 0.
   task automatic model_step();
      logic [31:0] om [32];
      logic        ob [32];
      int a;
      for (int k = 0; k < 32; k++) begin
         om[k] = m[k];
         ob[k] = bz[k];
      end
      for (int j = 0; j < 2; j++) begin
         a = int'(rd_s[j*AW +: AW]);
         if (we[j] && a != 0) begin
            m[a]  = rd_v[j*DW +: DW];
            bz[a] = 1'b0;
         end
      end
      if (rsv_en && rsv_s != 0) bz[rsv_s] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         a = int'(rs_s[i*AW +: AW]);
         if (rd_en[i]) begin
            ev_b[i] = m[a];  eb_b[i] = bz[a];
            ev_n[i] = om[a]; eb_n[i] = ob[a];
         end
      end
   endtask

   task automatic check_model(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s byp_v%0d", tag, i), v_byp[i*DW +: DW], ev_b[i]);
         chk($sformatf("%s byp_b%0d", tag, i), 32'(b_byp[i]), 32'(eb_b[i]));
         chk($sformatf("%s nb_v%0d", tag, i), v_nb[i*DW +: DW], ev_n[i]);
         chk($sformatf("%s nb_b%0d", tag, i), 32'(b_nb[i]), 32'(eb_n[i]));
      end
   endtask

   task automatic run_cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic idle();
      we = '0; rd_en = '0; rsv_en = 1'b0; rd_s = '0; rd_v = '0; rs_s = '0; rsv_s = '0;
   endtask

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic [1:0]  re;
      logic [4:0]  ra0, ra1;
      logic        rsv;
      logic [4:0]  rsa;
      logic [31:0] ev_byp, ev_nb;
      logic        eb_byp, eb_nb;
   } vec_t;

   vec_t vt [16];

   initial begin
      // expected values are for read port 0 after the clock edge
      vt[0]  = '{2'b01, 5,0, 32'hDEADBEEF,0, 2'b00, 0,0, 0,0, 32'h0,        32'h0,        0,0};
      vt[1]  = '{2'b00, 0,0, 0,0,            2'b11, 5,5, 0,0, 32'hDEADBEEF, 32'hDEADBEEF, 0,0};
      vt[2]  = '{2'b01, 0,0, 32'hFFFFFFFF,0, 2'b11, 0,0, 1,0, 32'h0,        32'h0,        0,0};
      vt[3]  = '{2'b00, 0,0, 0,0,            2'b11, 0,0, 0,0, 32'h0,        32'h0,        0,0};
      vt[4]  = '{2'b01, 7,0, 32'h1,0,        2'b00, 0,0, 0,0, 32'h0,        32'h0,        0,0};
      vt[5]  = '{2'b01, 7,0, 32'h2,0,        2'b11, 7,7, 0,0, 32'h2,        32'h1,        0,0};
      vt[6]  = '{2'b11, 3,3, 32'hA,32'hB,    2'b00, 0,0, 0,0, 32'h2,        32'h1,        0,0};
      vt[7]  = '{2'b00, 0,0, 0,0,            2'b11, 3,3, 0,0, 32'hB,        32'hB,        0,0};
      vt[8]  = '{2'b00, 0,0, 0,0,            2'b11, 9,9, 1,9, 32'h0,        32'h0,        1,0};
      vt[9]  = '{2'b00, 0,0, 0,0,            2'b11, 9,9, 0,0, 32'h0,        32'h0,        1,1};
      vt[10] = '{2'b01, 9,0, 32'h99,0,       2'b11, 9,9, 0,0, 32'h99,       32'h0,        0,1};
      vt[11] = '{2'b00, 0,0, 0,0,            2'b11, 9,9, 0,0, 32'h99,       32'h99,       0,0};
      vt[12] = '{2'b01, 9,0, 32'h55,0,       2'b11, 9,9, 1,9, 32'h55,       32'h99,       1,0};
      vt[13] = '{2'b00, 0,0, 0,0,            2'b11, 9,9, 0,0, 32'h55,       32'h55,       1,1};
      vt[14] = '{2'b01, 9,0, 32'h66,0,       2'b00, 0,0, 0,0, 32'h55,       32'h55,       1,1};
      vt[15] = '{2'b00, 0,0, 0,0,            2'b11, 9,9, 0,0, 32'h66,       32'h66,       0,0};

      model_reset();
      #12;
      check_model("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < 16; n++) begin
         we = vt[n].we;
         rd_s = {vt[n].wa1, vt[n].wa0};
         rd_v = {vt[n].wd1, vt[n].wd0};
         rd_en = vt[n].re;
         rs_s = {vt[n].ra1, vt[n].ra0};
         rsv_en = vt[n].rsv;
         rsv_s = vt[n].rsa;
         run_cycle($sformatf("vec%0d", n));
         chk($sformatf("vec%0d tbl_byp_v", n), v_byp[31:0], vt[n].ev_byp);
         chk($sformatf("vec%0d tbl_nb_v", n), v_nb[31:0], vt[n].ev_nb);
         chk($sformatf("vec%0d tbl_byp_b", n), 32'(b_byp[0]), 32'(vt[n].eb_byp));
         chk($sformatf("vec%0d tbl_nb_b", n), 32'(b_nb[0]), 32'(vt[n].eb_nb));
      end

      // Random traffic on a narrow address window to provoke collisions.
      for (int n = 0; n < 400; n++) begin
         we     = 2'($urandom_range(0, 3));
         rd_s   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         rd_v   = {32'($urandom), 32'($urandom)};
         rd_en  = 2'($urandom_range(0, 3));
         rs_s   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         rsv_en = 1'($urandom_range(0, 1));
         rsv_s  = 5'($urandom_range(0, 7));
         run_cycle("rand");
      end

      // Mid-run async reset with a write and reserve in flight.
      idle();
      we = 2'b01; rd_s = {5'd0, 5'd5}; rd_v = {32'h0, 32'hDEADBEEF};
      run_cycle("pre_rst_wr");
      idle();
      rd_en = 2'b11; rs_s = {5'd5, 5'd5};
      run_cycle("pre_rst_rd");
      chk("pre_rst_val", v_byp[31:0], 32'hDEADBEEF);
      we = 2'b01; rd_s = {5'd0, 5'd5}; rd_v = {32'h0, 32'h12345678};
      rsv_en = 1'b1; rsv_s = 5'd5;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_model("async_rst");
      @(posedge clk);
      #1;
      check_model("rst_held");
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      for (int a = 0; a < 32; a += 2) begin
         rd_en = 2'b11;
         rs_s = {5'(a + 1), 5'(a)};
         run_cycle("post_rst");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
